// File: rtl/reg_bank_datapath.sv
// Register file and inter-cycle holding registers (A, B, ALUOut, MDR) of the multicycle MIPS core.
// Write-back source and destination are chosen by the control unit's RegDst/MemparaReg.
`timescale 1ns/1ps
module reg_bank_datapath #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [$clog2(NREGS)-1:0]  rs,
    input  logic [$clog2(NREGS)-1:0]  rt,
    input  logic [$clog2(NREGS)-1:0]  rd,
    input  logic                      EscreveReg,
    input  logic                      RegDst,
    input  logic                      MemparaReg,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic [$clog2(NREGS)-1:0]  dbg_addr,
    output logic [DATA_W-1:0]         A,
    output logic [DATA_W-1:0]         B,
    output logic [DATA_W-1:0]         ALUOut,
    output logic [DATA_W-1:0]         MDR,
    output logic [DATA_W-1:0]         dbg_data
);
    localparam int AW = $clog2(NREGS);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_aluout;
    logic [DATA_W-1:0] r_mdr;

    logic [AW-1:0]     w_wa;
    logic [DATA_W-1:0] w_wd;
    logic              w_we;

    assign w_wa = RegDst ? rd : rt;
    assign w_wd = MemparaReg ? r_mdr : r_aluout;
    // Register 0 is hard-wired: writes to it are simply never issued.
    assign w_we = EscreveReg && (w_wa != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_wa] <= w_wd;
        end
    end

    // Holding registers load every edge from pre-edge array contents (no bypass).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
        end else begin
            r_a      <= (rs == '0) ? '0 : r_regs[rs];
            r_b      <= (rt == '0) ? '0 : r_regs[rt];
            r_aluout <= alu_result;
            r_mdr    <= mem_rdata;
        end
    end

    assign A        = r_a;
    assign B        = r_b;
    assign ALUOut   = r_aluout;
    assign MDR      = r_mdr;
    assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

endmodule

// File: tb/tb_reg_bank_datapath.sv
// Directed and randomized checks of reg_bank_datapath against an array-based reference model.
`timescale 1ns/1ps
module tb_reg_bank_datapath;
    logic        clock;
    logic        reset;
    logic [4:0]  rs, rt, rd, dbg_addr;
    logic        EscreveReg, RegDst, MemparaReg;
    logic [31:0] alu_result, mem_rdata;
    logic [31:0] A, B, ALUOut, MDR, dbg_data;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers plus the four holding registers.
    logic [31:0] mregs [32];
    logic [31:0] mA, mB, mALU, mMDR;

    reg_bank_datapath #(.DATA_W(32), .NREGS(32)) dut (
        .clock(clock), .reset(reset),
        .rs(rs), .rt(rt), .rd(rd),
        .EscreveReg(EscreveReg), .RegDst(RegDst), .MemparaReg(MemparaReg),
        .alu_result(alu_result), .mem_rdata(mem_rdata),
        .dbg_addr(dbg_addr),
        .A(A), .B(B), .ALUOut(ALUOut), .MDR(MDR), .dbg_data(dbg_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mA = 0; mB = 0; mALU = 0; mMDR = 0;
    endtask

    // Advance one rising edge: the model takes every value as it stood before the edge.
    task automatic tick();
        logic [4:0]  wa;
        logic [31:0] wd, nA, nB;
        wa = RegDst ? rd : rt;
        wd = MemparaReg ? mMDR : mALU;
        nA = mregs[rs];
        nB = mregs[rt];
        if (EscreveReg && wa != 5'd0) mregs[wa] = wd;
        mA = nA; mB = nB; mALU = alu_result; mMDR = mem_rdata;
        @(posedge clock); #1;
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".A"}, A, mA);
        check({tag, ".B"}, B, mB);
        check({tag, ".ALUOut"}, ALUOut, mALU);
        check({tag, ".MDR"}, MDR, mMDR);
    endtask

    task automatic peek(input logic [4:0] addr, output logic [31:0] val);
        dbg_addr = addr;
        #0.2;
        val = dbg_data;
    endtask

    // Walks dbg_addr over every register; fits between two edges.
    task automatic sweep(input string tag);
        logic [31:0] v;
        for (int i = 0; i < 32; i++) begin
            peek(5'(i), v);
            check($sformatf("%s.reg%0d", tag, i), v, mregs[i]);
        end
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1; rs = 0; rt = 0; rd = 0; dbg_addr = 0;
        EscreveReg = 0; RegDst = 0; MemparaReg = 0;
        alu_result = 0; mem_rdata = 0;
        model_clear();
        #1;
        check("por.A", A, 32'h0);
        check("por.B", B, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        tick();
        check_outs("idle");

        // 1: preload reg5, then asynchronous reset between edges
        alu_result = 32'h1234; tick();
        RegDst = 1; rd = 5; EscreveReg = 1; mem_rdata = 32'h55AA; rs = 5; rt = 5; tick();
        EscreveReg = 0; tick();
        peek(5'd5, v); check("pre_reset.reg5", v, 32'h1234);
        check("pre_reset.A", A, 32'h1234);
        reset = 1'b1; #1;
        model_clear();
        check_outs("reset_async");
        peek(5'd5, v); check("reset_async.reg5", v, 32'h0);
        EscreveReg = 1; alu_result = 32'hCAFE; mem_rdata = 32'hBEEF;
        @(posedge clock); #1;
        check_outs("reset_held");
        peek(5'd5, v); check("reset_held.reg5", v, 32'h0);
        reset = 1'b0; EscreveReg = 0;
        tick();
        check_outs("post_reset");

        // 2: R-type write-back from ALUOut
        alu_result = 32'hDEADBEEF; tick();
        RegDst = 1; rd = 9; MemparaReg = 0; EscreveReg = 1; rs = 0; rt = 0; tick();
        peek(5'd9, v); check("rtype.dbg9", v, 32'hDEADBEEF);
        EscreveReg = 0; rs = 9; tick();
        check("rtype.A", A, 32'hDEADBEEF);
        check_outs("rtype");

        // 3: load write-back from MDR into rt, rd untouched
        mem_rdata = 32'h0000_00FF; tick();
        RegDst = 0; rt = 4; rd = 9; MemparaReg = 1; EscreveReg = 1; tick();
        EscreveReg = 0;
        peek(5'd4, v); check("load.reg4", v, 32'hFF);
        peek(5'd9, v); check("load.reg9", v, 32'hDEADBEEF);

        // 4: writes to register 0 are dropped
        alu_result = 32'hFFFF_FFFF; MemparaReg = 0; tick();
        RegDst = 0; rt = 0; EscreveReg = 1; tick();
        peek(5'd0, v); check("r0.dbg", v, 32'h0);
        rs = 0; rt = 0; tick();
        EscreveReg = 0;
        check("r0.A", A, 32'h0);
        check("r0.B", B, 32'h0);

        // 5: same-edge write and read of reg3, no bypass
        alu_result = 32'h11; tick();
        RegDst = 1; rd = 3; EscreveReg = 1; tick();
        EscreveReg = 0; alu_result = 32'h22; tick();
        peek(5'd3, v); check("same.reg3_before", v, 32'h11);
        EscreveReg = 1; rs = 3; tick();
        check("same.A_old", A, 32'h11);
        EscreveReg = 0; tick();
        check("same.A_new", A, 32'h22);

        // 6: write disabled for 10 edges with live wa/wd
        EscreveReg = 0;
        for (int i = 0; i < 10; i++) begin
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom | 1);
            RegDst = 1'($urandom); MemparaReg = 1'($urandom);
            alu_result = $urandom; mem_rdata = $urandom;
            tick();
            check_outs($sformatf("nowr%0d", i));
        end
        sweep("nowr");

        // Randomized traffic against the model, with an occasional mid-run reset
        for (int i = 0; i < 400; i++) begin
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            RegDst = 1'($urandom); MemparaReg = 1'($urandom);
            EscreveReg = ($urandom_range(0, 3) != 0);
            alu_result = $urandom; mem_rdata = $urandom;
            if (i == 200) begin
                reset = 1'b1; #1;
                model_clear();
                check_outs("rand_reset");
                reset = 1'b0;
            end
            tick();
            check_outs($sformatf("rand%0d", i));
            peek(5'($urandom), v);
            check($sformatf("rand%0d.dbg%0d", i, dbg_addr), v, mregs[dbg_addr]);
            if (i % 100 == 99) sweep($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_bank_datapath.md
# reg_bank_datapath

Register file and inter-cycle datapath registers of the multicycle MIPS core. It sits directly downstream of the control unit and consumes its `EscreveReg`, `RegDst` and `MemparaReg` outputs. It holds the 32 general-purpose registers plus the A, B, ALUOut and MDR holding registers, and supplies operands to the ALU. It also performs register write-back from either ALUOut or MDR.

## Interface
- `DATA_W`, default 32, width of every register and data port.
- `NREGS`, default 32, number of architectural registers; index width is 5 bits (log2 NREGS).

Ports (clock and reset first):
- `clock`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rs`  in  5  instruction bits [25:21]; read port A index.
- `rt`  in  5  instruction bits [20:16]; read port B index and I-type destination.
- `rd`  in  5  instruction bits [15:11]; R-type destination.
- `EscreveReg`  in  1  register-file write enable.
- `RegDst`  in  1  destination select: 0 = `rt`, 1 = `rd`.
- `MemparaReg`  in  1  write-data select: 0 = ALUOut register, 1 = MDR register.
- `alu_result`  in  DATA_W  ALU output, captured into ALUOut.
- `mem_rdata`  in  DATA_W  memory read data, captured into MDR.
- `dbg_addr`  in  5  debug read index.
- `A`  out  DATA_W  registered operand A.
- `B`  out  DATA_W  registered operand B; also the store data.
- `ALUOut`  out  DATA_W  registered ALU result.
- `MDR`  out  DATA_W  registered memory data.
- `dbg_data`  out  DATA_W  combinational contents of register `dbg_addr`.

## Operation
- Register array: NREGS x DATA_W. Register 0 always reads 0, and writes to it are discarded.
- Write address `wa` = `RegDst ? rd : rt`. Write data `wd` = `MemparaReg ? MDR : ALUOut`. Both values are taken before the edge.
- On a rising edge with `EscreveReg`=1 and `wa`≠0, `regs[wa]` <= `wd`.
- A and B are loaded on every rising edge, with no enable: A <= `regs[rs]`, B <= `regs[rt]`. These reads use array contents before the same edge.
- ALUOut <= `alu_result` and MDR <= `mem_rdata` on every rising edge, with no enable.
- `dbg_data` = `regs[dbg_addr]` combinationally. Index 0 returns 0.
- No arithmetic is performed. All data paths are pass-through at DATA_W bits, with no extension or truncation.
- The block has no internal FSM. Sequencing is owned entirely by the control unit.

## Timing
- Reset (asynchronous, effective immediately on assertion): all 32 registers, A, B, ALUOut and MDR go to 0, and `dbg_data` reads 0. The state stays at 0 while `reset` is high, regardless of `EscreveReg` or the clock.
- Reset deasserting mid-instruction: the first edge after release behaves as a normal edge. No partial write survives the reset.
- Read latency: a change on `rs`/`rt` appears on A/B after 1 rising edge.
- Write-to-read, same register:
  - A write at edge N is visible on `dbg_data` immediately after edge N.
  - It is visible on A/B after edge N+1.
  - There is no bypass: A/B captured at edge N hold the old value.
- Write-back uses the ALUOut/MDR value latched at edge N-1. The result of an `alu_result` change is therefore writable no earlier than 2 edges after that change.
- Simultaneous `EscreveReg`=1 with `wa`=0: no state change; A/B still load normally.
- `rs`=`rt`: A and B capture the same value.

## Test plan
1. Reset:
   - Stimulus: pre-load `regs[5]`=0x1234 via write-back, then pulse `reset` between edges.
   - Required response: A, B, ALUOut, MDR and `dbg_data`(5) read 0 immediately, without waiting for a clock edge.
2. R-type write-back:
   - Stimulus: `alu_result`=0xDEADBEEF for one edge, then `RegDst`=1, `rd`=9, `MemparaReg`=0, `EscreveReg`=1 for one edge.
   - Required response: `dbg_data`(9)=0xDEADBEEF. With `rs`=9, A=0xDEADBEEF one edge later.
3. Load write-back:
   - Stimulus: `mem_rdata`=0x0000_00FF, then `RegDst`=0, `rt`=4, `MemparaReg`=1, `EscreveReg`=1.
   - Required response: `regs[4]`=0xFF; `regs[rd]` unchanged.
4. Register 0:
   - Stimulus: write 0xFFFFFFFF with `wa`=0.
   - Required response: `dbg_data`(0)=0. With `rs`=`rt`=0, A=B=0.
5. Same-edge read/write:
   - Stimulus: `regs[3]`=0x11. Write 0x22 to reg 3 with `rs`=3 on the same edge.
   - Required response: A=0x11 after that edge; A=0x22 after the next edge.
6. Write disabled:
   - Stimulus: `EscreveReg`=0 with valid `wa`/`wd` for 10 edges.
   - Required response: all registers unchanged; A/B/ALUOut/MDR track their inputs each edge.
